// File: rtl/rank_accumulator_pkg.sv
// rtl/rank_accumulator_pkg.sv - shared types and constants for the nibble-serial rank accumulator
// Contents: rank_acc_state_t FSM encoding, NIBBLE_W slice width, nib_count() width-to-nibble helper.
package rank_acc_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        OUT  = 2'd2
    } rank_acc_state_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/rank_accumulator_nibble_adder.sv
// rtl/rank_accumulator_nibble_adder.sv - combinational 4-bit ripple-carry slice
// Ports: a, b (4-bit addends), cin (carry in) -> sum (4-bit), cout (carry out).
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c      = '0;
        sum    = '0;
        c[0]   = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[4];

endmodule

// File: rtl/rank_accumulator.sv
// rtl/rank_accumulator.sv - nibble-serial accumulator summing one page's rank contributions
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_last operand stream;
//        out_valid/out_ready/out_sum/out_ovf total; busy (ADD or OUT).
// Build option: RANK_ACC_SAT_EN forces out_sum to all-ones while out_ovf is set.
module rank_accumulator
    import rank_acc_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIB = nib_count(ACC_W);
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    if (ACC_W % NIBBLE_W != 0 || ACC_W < NIBBLE_W) begin : g_bad_width
        $error("rank_accumulator: ACC_W must be a positive multiple of 4");
    end

    rank_acc_state_t state_q, state_d;

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    op_q;
    logic [KW-1:0]       k_q;
    logic                carry_q;
    logic                ovf_q;
    logic                last_q;

    logic                accept;
    logic                consume;
    logic [NIBBLE_W-1:0] acc_nib;
    logic [NIBBLE_W-1:0] op_nib;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    // One shared slice; the nibble counter steers which nibble feeds it.
    assign acc_nib = acc_q[int'(k_q)*NIBBLE_W +: NIBBLE_W];
    assign op_nib  = op_q[int'(k_q)*NIBBLE_W +: NIBBLE_W];

    nibble_adder u_nibble_adder (
        .a    (acc_nib),
        .b    (op_nib),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gated with rst_n so the port reads 0 while reset is held.
                in_ready = rst_n;
                if (in_valid) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (k_q == K_LAST) begin
                    state_d = last_q ? OUT : IDLE;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            op_q    <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= in_data;
                last_q  <= in_last;
                k_q     <= '0;
                carry_q <= 1'b0;
            end
            if (state_q == ADD) begin
                acc_q[int'(k_q)*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                carry_q <= nib_cout;
                k_q     <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
                // Only the carry out of the top nibble means the total wrapped.
                if (k_q == K_LAST) begin
                    ovf_q <= ovf_q | nib_cout;
                end
            end
            if (consume) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef RANK_ACC_SAT_EN
    assign out_sum = ovf_q ? {ACC_W{1'b1}} : acc_q;
`else
    assign out_sum = acc_q;
`endif

    assign out_ovf = ovf_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rank_accumulator.sv
// tb/tb_rank_accumulator.sv - scoreboard bench for rank_accumulator
module tb_rank_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [16:0] exp_q[$];

    rank_accumulator #(.ACC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_page(input logic [15:0] sum, input logic ovf);
        exp_q.push_back({ovf, sum});
    endtask

    // Offers one beat, then checks the NIB-cycle busy window and what follows it.
    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ready_low_in_add", 32'(in_ready), 32'd0);
            chk("valid_low_in_add", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        if (l) chk("valid_after_4_edges", 32'(out_valid), 32'd1);
        else   chk("ready_after_4_edges", 32'(in_ready), 32'd1);
    endtask

    // Monitor: pops and compares whenever a total is handed over.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_sum);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("out_sum", 32'(out_sum), 32'(e[15:0]));
                    chk("out_ovf", 32'(out_ovf), 32'(e[16]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_out_sum", 32'(out_sum), 32'h0000);
        chk("rel_out_ovf", 32'(out_ovf), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);

        // Basic sum
        send(16'h0001, 1'b0);
        send(16'h000F, 1'b0);
        expect_page(16'h0100, 1'b0);
        send(16'h00F0, 1'b1);

        // Full carry chain
        send(16'h0FFF, 1'b0);
        expect_page(16'h1000, 1'b0);
        send(16'h0001, 1'b1);

        // Overflow, then a clean page
        send(16'hFFFF, 1'b0);
`ifdef RANK_ACC_SAT_EN
        expect_page(16'hFFFF, 1'b1);
`else
        expect_page(16'h0001, 1'b1);
`endif
        send(16'h0002, 1'b1);
        expect_page(16'h0003, 1'b0);
        send(16'h0003, 1'b1);

        // Backpressure with a competing offer
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(16'h00FF, 1'b0);
        expect_page(16'h0100, 1'b0);
        send(16'h0001, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_sum", 32'(out_sum), 32'h0100);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        chk("bp_ready_rise", 32'(in_ready), 32'd1);
        expect_page(16'h0005, 1'b0);
        send(16'h0005, 1'b1);

        // Reset in the middle of an add
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h00FF;
        in_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_sum", 32'(out_sum), 32'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rel_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rel_out_ovf", 32'(out_ovf), 32'd0);
        expect_page(16'h0010, 1'b0);
        send(16'h0010, 1'b1);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rank_accumulator.md
# rank_accumulator

Nibble-serial accumulator for the PageRank datapath. It sums a stream of ACC_W-bit rank contributions (one in-link per beat) into a running total for one page. Each operand is pushed through a single 4-bit ripple-carry slice over ACC_W/4 cycles, with the carry held in a flop between nibbles. The total is presented on a valid/ready output when the beat flagged `in_last` finishes.

## Interface
- `ACC_W`, default 16: accumulator and operand width. Must be a multiple of 4; any other value is an elaboration error.
- `NIB`, derived as ACC_W/4 (not overridable): nibble cycles per operand.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  operand beat offered.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  ACC_W  unsigned contribution.
- `in_last`  in  1  final contribution for this page.
- `out_valid`  out  1  total available.
- `out_ready`  in  1  consumer takes the total.
- `out_sum`  out  ACC_W  accumulated total.
- `out_ovf`  out  1  sticky overflow for this page.
- `busy`  out  1  high in ADD or OUT.

## Operation
- **States.** IDLE, ADD, OUT.
- **IDLE.**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_data` and `in_last`, nibble index k←0, carry←0, go to ADD.
- **ADD.**
  - `in_ready`=0.
  - Each cycle: {cout,s} = acc[4k+3:4k] + op[4k+3:4k] + carry.
  - On the edge: acc nibble k←s, carry←cout, k←k+1.
  - At k==NIB-1: `out_ovf`←`out_ovf`|cout. Then go to OUT if the latched last is set, else IDLE.
- **OUT.**
  - `out_valid`=1, `in_ready`=0.
  - `out_sum` and `out_ovf` are held stable while `out_ready`=0.
  - On `out_ready`: acc←0, `out_ovf`←0, go to IDLE.
- **Arithmetic.** Unsigned, modulo 2^ACC_W. An overflow on any beat sets `out_ovf` until the total is consumed.
- **Zero operand.** Still takes NIB cycles.
- **Ignored inputs.** `in_valid` in ADD/OUT is ignored and no data is captured. `out_ready` outside OUT is ignored.
- **Reset.**
  - Asserting `rst_n` in any state, including mid-ADD, clears state to IDLE, acc, op, k, carry and `out_ovf`. The partial sum is discarded.
  - Reset values: `in_ready`=0 while `rst_n` is low and 1 from the first cycle after release; `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0.

## Timing
- An accepting edge E0 puts the block in ADD.
- Nibble k is written on edge E0+k+1.
- Non-last beat: `in_ready` is high again after edge E0+NIB. Throughput is one operand per NIB+1 cycles (5 at default).
- Last beat: `out_valid` rises after edge E0+NIB (4 edges at default). `out_sum` is registered, with no combinational path from inputs.
- Consumption: `out_valid` drops and `in_ready` rises on the edge where `out_valid`&&`out_ready`. A new page can be accepted on the following edge.
- No same-cycle input→output paths, except `in_ready` and `out_valid`, which are decoded from the registered state only.

## Configuration
- **`RANK_ACC_SAT_EN` defined:** `out_sum` = all-ones whenever `out_ovf`=1 (output mux only). Internal acc still wraps.
- **`RANK_ACC_SAT_EN` undefined:** `out_sum` = acc modulo 2^ACC_W. `out_ovf` is still reported.
- Cycle timing is identical in both builds.

## Structure
- **Package `rank_acc_pkg`:**
  - state enum `rank_acc_state_t` (IDLE, ADD, OUT);
  - constant `NIBBLE_W`=4;
  - function returning the nibble count for a width.
- **Sub-module `nibble_adder`:** combinational 4-bit ripple slice, ports a[3:0], b[3:0], cin → sum[3:0], cout. Instantiated once and shared across nibbles.
- **Top:** FSM, nibble counter, operand/acc registers, carry flop, saturation mux.

## Test plan
- **Reset:** hold `rst_n` low 3 cycles, release → `in_ready`=1, `out_valid`=0, `out_sum`=0x0000, `out_ovf`=0.
- **Basic sum:** beats 0x0001, 0x000F, 0x00F0 (last) → `out_sum`=0x0100, `out_ovf`=0; `out_valid` rises 4 edges after the third accept; `in_ready` low for 4 cycles after each accept.
- **Full carry chain:** 0x0FFF then 0x0001 (last) → `out_sum`=0x1000, `out_ovf`=0.
- **Overflow:** 0xFFFF then 0x0002 (last).
  - Without the macro: `out_sum`=0x0001, `out_ovf`=1.
  - With `RANK_ACC_SAT_EN`: `out_sum`=0xFFFF, `out_ovf`=1.
  - Next page 0x0003 (last) → 0x0003, `out_ovf`=0.
- **Backpressure:** total 0x0100 held with `out_ready`=0 for 10 cycles while `in_valid`=1 with 0x1234 → `out_sum` stable, no capture. Raise `out_ready` → `out_valid` drops. Then 0x0005 (last) → 0x0005.
- **Mid-op reset:** pulse `rst_n` low 2 cycles after accepting 0x00FF → all outputs at reset values. Then 0x0010 (last) → `out_sum`=0x0010.
